// File: rtl/neural_mem_pkg.sv
// Shared definitions for the neural-accelerator memory path: word/address
// widths matching the SDRAM controller and the fetch engine state encoding.
package neural_mem_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage (no fall-through). Flush has
// priority over push/pop; a simultaneous push and pop keeps the count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == '0);
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // Qualify requests so an overflow or underflow can never corrupt pointers.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_dma.sv
// Read-only fetch engine: turns one (base, length, stride) command into
// single-word reads on the controller handshake and streams the returned
// words out of a small buffer to the MAC array loader.
module weight_fetch_dma
    import neural_mem_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        stride,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    fetch_state_t      state_r;
    fetch_state_t      state_n;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [LEN_W-1:0]  remaining_r;
    logic [7:0]        stride_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              error_r;
    logic              done_r;

    logic              mem_rd_en_s;
    logic              accept_s;
    logic              zero_len_s;
    logic              push_s;
    logic              timeout_s;
    logic              drain_done_s;
    logic              flush_s;
    logic              pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;

    // Only one request is ever outstanding, so checking space at issue time
    // guarantees the returned word has a free slot.
    assign mem_rd_en_s = (state_r == ISSUE) && (fifo_count_s < CNT_W'(FIFO_DEPTH));
    assign pop_s       = !fifo_empty_s && out_ready;

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign error     = error_r;
    assign mem_rd_en = mem_rd_en_s;
    assign mem_addr  = mem_rd_en_s ? addr_r : addr_hold_r;
    assign out_valid = !fifo_empty_s;

    // Next-state and per-cycle control strobes; abort outranks everything.
    always_comb begin
        state_n      = state_r;
        accept_s     = 1'b0;
        zero_len_s   = 1'b0;
        push_s       = 1'b0;
        timeout_s    = 1'b0;
        drain_done_s = 1'b0;
        flush_s      = 1'b0;
        if (abort && (state_r != IDLE)) begin
            state_n = IDLE;
            flush_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (length != '0)) begin
                        accept_s = 1'b1;
                        state_n  = ISSUE;
                    end else if (start) begin
                        zero_len_s = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_rd_en_s) begin
                        state_n = WAIT;
                    end else begin
                        state_n = ISSUE;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        push_s  = !fifo_full_s;
                        state_n = (remaining_r == LEN_W'(1)) ? DRAIN : ISSUE;
                    end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                        timeout_s = 1'b1;
                        flush_s   = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        state_n = WAIT;
                    end
                end
                DRAIN: begin
                    if (fifo_empty_s) begin
                        drain_done_s = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        state_n = DRAIN;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State register and the registered completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            done_r  <= drain_done_s || zero_len_s;
        end
    end

    // Address/length counters, sticky error flag and request timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r      <= '0;
            addr_hold_r <= '0;
            remaining_r <= '0;
            stride_r    <= '0;
            to_cnt_r    <= '0;
            error_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r      <= base_addr;
                remaining_r <= length;
                stride_r    <= stride;
            end else if (push_s) begin
                addr_r      <= addr_r + {{(ADDR_W-8){1'b0}}, stride_r};
                remaining_r <= remaining_r - LEN_W'(1);
            end
            if (accept_s || zero_len_s) begin
                error_r <= 1'b0;
            end else if (timeout_s) begin
                error_r <= 1'b1;
            end
            if (mem_rd_en_s) begin
                to_cnt_r    <= '0;
                addr_hold_r <= addr_r;
            end else if (state_r == WAIT) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .wdata   (mem_rdata),
        .rdata   (out_data),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

endmodule

// File: tb/tb_weight_fetch_dma.sv
// Self-checking bench for weight_fetch_dma: a behavioural controller model,
// a randomisable sink, and a monitor logging requests, popped words and done.
module tb_weight_fetch_dma;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] length;
    logic [7:0]  stride;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    int tests = 0;
    int fails = 0;

    logic [23:0] req_q [$];
    logic [15:0] got_q [$];
    int          done_total = 0;
    int          viol_total = 0;

    int          resp_n = 0;
    int          silent_at = 32'h3fff_ffff;
    int          late_at = -1;
    bit          rand_delay = 1'b0;
    int          sink_mode = 1;
    logic [23:0] resp_addr;
    int          resp_d;

    weight_fetch_dma dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .stride    (stride),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Memory contents seen through the controller: word = 3 * address.
    function automatic logic [15:0] mem_word(input logic [23:0] a);
        logic [25:0] p;
        p = {2'b00, a} * 26'd3;
        return p[15:0];
    endfunction

    // i-th address of a command: base + i*stride modulo 2^24.
    function automatic logic [23:0] exp_addr(input logic [23:0] b, input logic [7:0] s, input int i);
        return b + 24'(i) * {16'd0, s};
    endfunction

    // Index of first wrong request address since r0 (-1 when all correct).
    function automatic int first_bad_addr(input logic [23:0] b, input int l, input logic [7:0] s, input int r0);
        for (int i = 0; i < l; i++) begin
            if (r0 + i >= req_q.size()) return i;
            if (req_q[r0 + i] !== exp_addr(b, s, i)) return i;
        end
        if (req_q.size() - r0 > l) return l;
        return -1;
    endfunction

    // Index of first wrong delivered word since g0 (-1 when all correct).
    function automatic int first_bad_data(input logic [23:0] b, input int l, input logic [7:0] s, input int g0);
        for (int i = 0; i < l; i++) begin
            if (g0 + i >= got_q.size()) return i;
            if (got_q[g0 + i] !== mem_word(exp_addr(b, s, i))) return i;
        end
        if (got_q.size() - g0 > l) return l;
        return -1;
    endfunction

    // Monitor: requests, accepted output words, done cycles, stray requests.
    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            req_q.push_back(mem_addr);
            if (busy !== 1'b1) viol_total++;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
        if (done === 1'b1) done_total++;
    end

    // Controller model: ready one cycle after the request edge (plus optional delay).
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_rd_en === 1'b1 && resp_n < silent_at) begin
                resp_addr = mem_addr;
                if (resp_n == late_at) resp_d = 6;
                else if (rand_delay) resp_d = $urandom_range(0, 3);
                else resp_d = 0;
                resp_n++;
                @(posedge clk);
                repeat (resp_d) @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_rdata = mem_word(resp_addr);
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    // Sink model: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (sink_mode == 1) ? 1'b1 : (sink_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic start_cmd(input logic [23:0] b, input logic [15:0] l, input logic [7:0] s);
        @(posedge clk);
        #1;
        base_addr = b;
        length    = l;
        stride    = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, busy, bound);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; base_addr = 24'h0; length = 16'h0; stride = 8'h0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, error, mem_rd_en, out_valid} !== 5'b00000 || mem_addr !== 24'h0 || out_data !== 16'h0) begin
            fails++;
            $display("FAIL reset: busy/done/err/rd/vld=%b%b%b%b%b addr=%h data=%h, expected all 0",
                     busy, done, error, mem_rd_en, out_valid, mem_addr, out_data);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int r0 = req_q.size(), g0 = got_q.size(), d0 = done_total, bad;
        sink_mode = 1;
        start_cmd(24'h000100, 16'd4, 8'd1);
        @(negedge clk);
        tests++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 24'h000100 || out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_first_req: rd=%b addr=%h vld=%b busy=%b, expected 1 000100 0 1", mem_rd_en, mem_addr, out_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early_valid: out_valid=%b, expected 0", out_valid);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h0300) begin
            fails++;
            $display("FAIL basic_first_word: vld=%b data=%h, expected 1 0300", out_valid, out_data);
        end
        wait_idle("basic", 200);
        bad = first_bad_addr(24'h000100, 4, 8'd1, r0);
        tests++;
        if (bad !== -1) begin
            fails++;
            $display("FAIL basic_addr: index %0d wrong, got %0d requests, expected 4", bad, req_q.size() - r0);
        end
        bad = first_bad_data(24'h000100, 4, 8'd1, g0);
        tests++;
        if (bad !== -1) begin
            fails++;
            $display("FAIL basic_data: index %0d wrong, got %0d words, expected 4", bad, got_q.size() - g0);
        end
        tests++;
        if (done_total - d0 !== 1 || error !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done cycles=%0d error=%b, expected 1 0", done_total - d0, error);
        end
    endtask

    task automatic test_backpressure();
        int r0 = req_q.size(), g0 = got_q.size(), d0 = done_total, bad;
        logic [23:0] b = 24'($urandom);
        sink_mode = 0;
        start_cmd(b, 16'd20, 8'd1);
        repeat (60) @(posedge clk);
        #1;
        tests++;
        if (req_q.size() - r0 !== 8 || mem_rd_en !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall: requests=%0d rd=%b vld=%b busy=%b, expected 8 0 1 1",
                     req_q.size() - r0, mem_rd_en, out_valid, busy);
        end
        sink_mode = 1;
        wait_idle("bp", 500);
        bad = first_bad_addr(b, 20, 8'd1, r0);
        tests++;
        if (bad !== -1) begin
            fails++;
            $display("FAIL bp_addr: index %0d wrong, got %0d requests, expected 20", bad, req_q.size() - r0);
        end
        bad = first_bad_data(b, 20, 8'd1, g0);
        tests++;
        if (bad !== -1 || done_total - d0 !== 1) begin
            fails++;
            $display("FAIL bp_data: bad index %0d, done cycles=%0d, expected -1 and 1", bad, done_total - d0);
        end
    endtask

    task automatic test_wrap();
        int r0 = req_q.size(), g0 = got_q.size(), bad;
        sink_mode = 1;
        start_cmd(24'hFFFFFE, 16'd3, 8'd2);
        wait_idle("wrap", 200);
        tests++;
        if (req_q.size() - r0 !== 3 || req_q[r0] !== 24'hFFFFFE || req_q[r0+1] !== 24'h000000 || req_q[r0+2] !== 24'h000002) begin
            fails++;
            $display("FAIL wrap_addr: got %0d requests, expected FFFFFE 000000 000002", req_q.size() - r0);
        end
        bad = first_bad_data(24'hFFFFFE, 3, 8'd2, g0);
        tests++;
        if (bad !== -1) begin
            fails++;
            $display("FAIL wrap_data: index %0d wrong, expected all 3 words", bad);
        end
    endtask

    task automatic test_random();
        rand_delay = 1'b1;
        sink_mode  = 2;
        for (int k = 0; k < 6; k++) begin
            int r0 = req_q.size(), g0 = got_q.size(), d0 = done_total, ba, bd;
            logic [23:0] b = 24'($urandom);
            logic [15:0] l = 16'($urandom_range(1, 30));
            logic [7:0]  s = 8'($urandom);
            start_cmd(b, l, s);
            wait_idle("random", 3000);
            ba = first_bad_addr(b, int'(l), s, r0);
            bd = first_bad_data(b, int'(l), s, g0);
            tests++;
            if (ba !== -1 || bd !== -1 || done_total - d0 !== 1) begin
                fails++;
                $display("FAIL random_cmd%0d: base=%h len=%0d stride=%0d bad addr idx=%0d bad data idx=%0d done=%0d, expected -1 -1 1",
                         k, b, l, s, ba, bd, done_total - d0);
            end
        end
        rand_delay = 1'b0;
    endtask

    task automatic test_timeout();
        int r0 = req_q.size(), d0, g0, n = 0, k = 0;
        logic [23:0] b = 24'($urandom);
        sink_mode = 0;
        silent_at = resp_n + 2;
        start_cmd(b, 16'd6, 8'd1);
        while (req_q.size() - r0 < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (out_valid !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_prebuf: vld=%b err=%b, expected 1 0", out_valid, error);
        end
        while (error !== 1'b1 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests++;
        if (k !== 255 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err: WAIT cycles=%0d busy=%b vld=%b, expected 255 0 0", k, busy, out_valid);
        end
        d0 = done_total;
        silent_at = 32'h3fff_ffff;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (error !== 1'b1 || done_total !== d0) begin
            fails++;
            $display("FAIL timeout_sticky: err=%b done cycles=%0d, expected 1 0", error, done_total - d0);
        end
        sink_mode = 1;
        g0 = got_q.size();
        start_cmd(b, 16'd1, 8'd0);
        tests++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: err=%b after new start, expected 0", error);
        end
        wait_idle("timeout_next", 200);
        tests++;
        if (got_q.size() - g0 !== 1 || got_q[g0] !== mem_word(b)) begin
            fails++;
            $display("FAIL timeout_next_data: words=%0d, expected 1 word %h", got_q.size() - g0, mem_word(b));
        end
    endtask

    task automatic test_abort();
        int r0 = req_q.size(), g0 = got_q.size(), d0 = done_total, n = 0;
        sink_mode = 0;
        late_at = resp_n + 3;
        start_cmd(24'($urandom), 16'd10, 8'd1);
        while (req_q.size() - r0 < 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: vld=%b busy=%b, expected 1 1", out_valid, busy);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%b vld=%b, expected 0 0", busy, out_valid);
        end
        repeat (12) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done_total !== d0 || got_q.size() !== g0 || error !== 1'b0) begin
            fails++;
            $display("FAIL abort_late_ready: busy=%b vld=%b done=%0d words=%0d err=%b, expected 0 0 0 0 0",
                     busy, out_valid, done_total - d0, got_q.size() - g0, error);
        end
        late_at = -1;
    endtask

    task automatic test_zero_len_and_busy_start();
        int r0 = req_q.size(), g0, d0, bad;
        logic [23:0] b1 = 24'($urandom);
        sink_mode = 1;
        start_cmd(24'h123456, 16'd0, 8'd1);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_done: done=%b busy=%b, expected 1 0", done, busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || req_q.size() !== r0) begin
            fails++;
            $display("FAIL zero_len_pulse: done=%b requests=%0d, expected 0 0", done, req_q.size() - r0);
        end
        r0 = req_q.size(); g0 = got_q.size(); d0 = done_total;
        start_cmd(b1, 16'd3, 8'd1);
        start_cmd(24'h000040, 16'd5, 8'd4);
        wait_idle("busy_start", 200);
        bad = first_bad_addr(b1, 3, 8'd1, r0);
        tests++;
        if (bad !== -1 || first_bad_data(b1, 3, 8'd1, g0) !== -1 || done_total - d0 !== 1) begin
            fails++;
            $display("FAIL busy_start: bad addr idx=%0d requests=%0d done=%0d, expected -1 3 1",
                     bad, req_q.size() - r0, done_total - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_random();
        test_timeout();
        test_abort();
        test_zero_len_and_busy_start();
        tests++;
        if (viol_total !== 0) begin
            fails++;
            $display("FAIL rd_en_idle: %0d requests outside busy, expected 0", viol_total);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
